lcd_access_arbiter: RTL and testbench
=====================================

// Module: lcd_access_arbiter
// PURPOSE
//  Sequences and shares the single LCD bus engine (lcd_interface) between two requesters: req 0 = lcd_init
//  power-up sequencer, req 1 = CPU-side LCD register bridge. Grants one transaction at a time,
//  drives the engine's we/wr/rs/data/id_fm/read_color, tracks busy, returns read data, flags hung engine.
// PARAMETERS
//  START_TO  16  max cycles from we pulse to busy=1 before timeout error (>=2)
//  DONE_TO   4096  max cycles with busy=1 before timeout error
// PORTS
//  pclk         in   1   clock (50 MHz)
//  rst          in   1   asynchronous, active-high reset
//  init_active  in   1   1: req 0 has absolute priority; 0: round-robin
//  req_valid    in   2   per-requester transaction request, held until req_done
//  req_rs       in   2   per-requester rs (0 inst, 1 data)
//  req_data     in   2x16  per-requester write word / command
//  req_is_read  in   2   1: write command then read back; 0: write only
//  req_id_fm    in   2   read timing select (0 id, 1 fm)
//  req_rd_color in   2   1: two read beats
//  req_grant    out  2   one-hot, high from ISSUE through RESP
//  req_done     out  2   one-cycle pulse to granted requester at end of transaction
//  req_err      out  1   sticky timeout flag, cleared only by reset
//  req_rdata    out  32  read result, valid with req_done when is_read
//  lcd_we       out  1   start pulse to engine
//  lcd_wr       out  1   1 write-only, 0 write-then-read
//  lcd_rs_o     out  1   to engine lcd_rs_i
//  lcd_data     out  16  to engine data_i
//  lcd_id_fm    out  1   to engine id_fm
//  lcd_rd_color out  1   to engine read_color
//  lcd_busy     in   1   engine busy
//  lcd_data_reg in   32  engine read shift register
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_last=1 (so req 0 wins first contended round-robin).
//  FSM: IDLE -> ISSUE -> WAIT_START -> WAIT_DONE -> RESP -> IDLE; ERROR is a recovery state.
//  IDLE: if any req_valid: pick winner (init_active -> req 0 if valid; else round-robin:
//   the requester != rr_last if valid). Latch winner's rs/data/is_read/id_fm/rd_color into regs.
//  ISSUE (1 cycle): lcd_we=1; lcd_wr=~is_read; other lcd_* from latched regs. grant set.
//  lcd_rs_o/lcd_data/lcd_id_fm/lcd_rd_color stable from ISSUE through RESP.
//  WAIT_START: exit to WAIT_DONE when lcd_busy=1; after START_TO cycles without busy -> ERROR.
//  WAIT_DONE: while lcd_busy=1 sample lcd_data_reg into shadow each cycle (engine clears
//   data_reg on same edge busy falls; shadow keeps last valid value). busy=0 -> RESP.
//   Counter > DONE_TO -> ERROR.
//  RESP (1 cycle): req_done[winner]=1; req_rdata=shadow if is_read else 0; rr_last=winner.
//  ERROR (1 cycle): req_err<=1 (sticky), req_done[winner]=1, rdata=0, -> IDLE.
//  Requester dropping req_valid mid-transaction: ignored; transaction completes.
//  init_active toggling mid-transaction affects only the next arbitration.
//  Min transaction = 1+1+busy span+1 cycles; back-to-back: new ISSUE no earlier than 1 cycle after RESP.
//  Async reset mid-transaction: outputs to reset values immediately; engine reset separately.
//  Timeout counters 16 bit, saturating, cleared on entering WAIT_START/WAIT_DONE.
// STRUCTURE
//  Shared package lcd_pkg: state enum arb_state_t, lcd_req_t struct {rs, data[15:0],
//   is_read, id_fm, rd_color}, REQ_INIT=0 / REQ_CPU=1 constants.
//  One sub-module: lcd_rr_pick2 (2-way round-robin pick with priority override, combinational).
// TESTING
//  Init write: init_active=1, req0 rs=0 data=16'h0011 -> one lcd_we pulse, lcd_wr=1,
//   lcd_data=0011 held until busy falls, req_done[0] 1 cycle later.
//  ID read: req1 is_read=1 data=16'h00D3 id_fm=0, engine model returns 32'h00009341 ->
//   lcd_wr=0, req_rdata=32'h00009341 with req_done[1].
//  Contention: both valid, init_active=0, rr_last=1 -> order req0,req1,req0; init_active=1 -> req0 only.
//  Start timeout: engine model never asserts busy -> req_err=1 after START_TO cycles, req_done pulses, FSM IDLE.
//  Reset in WAIT_DONE: assert rst -> grant/done/we all 0 same cycle, err cleared, next request served normally.
//  Color read: rd_color=1 two beats 16'h1234,16'h5678 -> req_rdata=32'h12345678.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and requester ids for the LCD bus arbiter slice.
package lcd_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP, ERROR} arb_state_t;
    typedef struct packed {
        logic        rs;
        logic [15:0] data;
        logic        is_read;
        logic        id_fm;
        logic        rd_color;
    } lcd_req_t;
    localparam logic REQ_INIT = 1'b0;
    localparam logic REQ_CPU  = 1'b1;
endpackage

// File: rtl/lcd_rr_pick2.sv
// lcd_rr_pick2: 2-way round-robin pick; prio forces the init requester when it is valid.
module lcd_rr_pick2
    import lcd_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       prio,
    input  logic       last,
    output logic       any,
    output logic       idx
);
    logic other;
    always_comb begin
        other = last ? REQ_INIT : REQ_CPU;
        any   = |valid;
        idx   = (prio && valid[REQ_INIT]) ? REQ_INIT : valid[other] ? other : last;
    end
endmodule

// File: rtl/lcd_access_arbiter.sv
// lcd_access_arbiter: shares one lcd_interface engine between lcd_init and the CPU bridge,
// one transaction at a time, with start/done timeouts raising a sticky error.
module lcd_access_arbiter
    import lcd_pkg::*;
#(
    parameter int START_TO = 16,
    parameter int DONE_TO  = 4096
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             init_active,
    input  logic [1:0]       req_valid,
    input  logic [1:0]       req_rs,
    input  logic [1:0][15:0] req_data,
    input  logic [1:0]       req_is_read,
    input  logic [1:0]       req_id_fm,
    input  logic [1:0]       req_rd_color,
    output logic [1:0]       req_grant,
    output logic [1:0]       req_done,
    output logic             req_err,
    output logic [31:0]      req_rdata,
    output logic             lcd_we,
    output logic             lcd_wr,
    output logic             lcd_rs_o,
    output logic [15:0]      lcd_data,
    output logic             lcd_id_fm,
    output logic             lcd_rd_color,
    input  logic             lcd_busy,
    input  logic [31:0]      lcd_data_reg
);
    arb_state_t  state, state_nx;
    lcd_req_t    cur, pick_req;
    logic        win, rr_last, pick_any, pick_idx, owned, fin;
    logic [15:0] cnt;
    logic [31:0] shadow;

    lcd_rr_pick2 u_pick (
        .valid (req_valid),
        .prio  (init_active),
        .last  (rr_last),
        .any   (pick_any),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_req = '{rs: req_rs[pick_idx], data: req_data[pick_idx], is_read: req_is_read[pick_idx],
                     id_fm: req_id_fm[pick_idx], rd_color: req_rd_color[pick_idx]};
        state_nx = state;
        case (state)
            IDLE:       state_nx = pick_any ? ISSUE : IDLE;
            ISSUE:      state_nx = WAIT_START;
            WAIT_START: state_nx = lcd_busy ? WAIT_DONE : (cnt >= 16'(START_TO - 1)) ? ERROR : WAIT_START;
            WAIT_DONE:  state_nx = !lcd_busy ? RESP : (cnt > 16'(DONE_TO)) ? ERROR : WAIT_DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        owned        = state != IDLE;
        fin          = state == RESP || state == ERROR;
        req_grant    = owned ? 2'b01 << win : 2'b00;
        req_done     = fin ? 2'b01 << win : 2'b00;
        req_rdata    = (state == RESP && cur.is_read) ? shadow : 32'h0;
        lcd_we       = state == ISSUE;
        lcd_wr       = owned && !cur.is_read;
        lcd_rs_o     = cur.rs;
        lcd_data     = cur.data;
        lcd_id_fm    = cur.id_fm;
        lcd_rd_color = cur.rd_color;
    end

    // The engine clears data_reg on the edge busy falls, so shadow holds the last busy-cycle value.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cur     <= '0;
            win     <= 1'b0;
            rr_last <= 1'b1;
            cnt     <= '0;
            shadow  <= '0;
            req_err <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state_nx != state) ? 16'h0 : cnt + 16'(cnt != 16'hFFFF);
            if (state == IDLE && pick_any) begin
                cur <= pick_req;
                win <= pick_idx;
            end
            if (state == WAIT_DONE && lcd_busy) shadow <= lcd_data_reg;
            if (state == RESP) rr_last <= win;
            if (state == ERROR) req_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lcd_access_arbiter.sv
// tb_lcd_access_arbiter: directed bench with a transaction-level reference model and a
// simple lcd_interface engine model that answers lcd_we with a busy span and read beats.
module tb_lcd_access_arbiter;
    import lcd_pkg::*;
    localparam int START_TO = 16;

    logic             pclk = 1'b0;
    logic             rst;
    logic             init_active = 1'b0;
    logic [1:0]       req_valid = '0, req_rs = '0, req_is_read = '0, req_id_fm = '0, req_rd_color = '0;
    logic [1:0][15:0] req_data = '0;
    logic [1:0]       req_grant, req_done;
    logic             req_err, lcd_we, lcd_wr, lcd_rs_o, lcd_id_fm, lcd_rd_color;
    logic [31:0]      req_rdata;
    logic [15:0]      lcd_data;
    logic             lcd_busy = 1'b0;
    logic [31:0]      lcd_data_reg = '0;

    lcd_access_arbiter #(.START_TO(START_TO), .DONE_TO(4096)) dut (
        .pclk(pclk), .rst(rst), .init_active(init_active), .req_valid(req_valid), .req_rs(req_rs),
        .req_data(req_data), .req_is_read(req_is_read), .req_id_fm(req_id_fm), .req_rd_color(req_rd_color),
        .req_grant(req_grant), .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
        .lcd_we(lcd_we), .lcd_wr(lcd_wr), .lcd_rs_o(lcd_rs_o), .lcd_data(lcd_data), .lcd_id_fm(lcd_id_fm),
        .lcd_rd_color(lcd_rd_color), .lcd_busy(lcd_busy), .lcd_data_reg(lcd_data_reg)
    );

    always #10 pclk = ~pclk;

    int n_run = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Engine model: busy rises eng_dly cycles after the we pulse and lasts eng_span cycles.
    int          eng_dly = 1, eng_span = 4;
    bit          eng_dead = 0;
    logic [31:0] eng_res = '0;
    initial begin
        forever begin
            @(negedge pclk);
            if (lcd_we && !rst && !eng_dead) begin
                for (int i = 1; i < eng_dly + eng_span; i++) begin
                    @(posedge pclk); #2;
                    if (rst) break;
                    if (i >= eng_dly) begin
                        lcd_busy = 1'b1;
                        lcd_data_reg = (i == eng_dly) ? 32'h0 : (i == eng_dly + 1) ? {16'h0, eng_res[31:16]} : eng_res;
                    end
                end
                @(posedge pclk); #2;
                lcd_busy = 1'b0;
                lcd_data_reg = '0;
            end
        end
    end

    // Reference model: tracks ownership as a transaction and derives each cycle's outputs.
    int          owner = -1, k, m_rr = 1, w;
    bit          cool, s2, b1, m_err, ewe, eto, eok;
    logic [1:0]  pv = '0;
    logic        pinit = 1'b0;
    logic [31:0] last_dr;
    lcd_req_t    pr[2], cur;
    int          wins[$], lats[$];
    logic [31:0] rds[$];

    always @(negedge pclk) begin
        if (rst) begin
            chk("rst_grant", 32'(req_grant), 0);
            chk("rst_done", 32'(req_done), 0);
            chk("rst_we", 32'(lcd_we), 0);
            chk("rst_err", 32'(req_err), 0);
            chk("rst_data", 32'(lcd_data), 0);
            owner = -1; cool = 0; m_rr = 1; m_err = 0; pv = '0;
        end else begin
            chk("err", 32'(req_err), 32'(m_err));
            if (owner < 0) begin
                ewe = !cool && pv != 0;
                chk("we", 32'(lcd_we), 32'(ewe));
                if (ewe) begin
                    w = (pinit && pv[0]) ? 0 : pv[1 - m_rr] ? 1 - m_rr : m_rr;
                    owner = w; cur = pr[w]; k = 0; s2 = 0; b1 = 0; last_dr = '0;
                    chk("wr", 32'(lcd_wr), 32'(!cur.is_read));
                    chk("grant", 32'(req_grant), 32'(1 << w));
                end else chk("grant_idle", 32'(req_grant), 0);
                chk("done_idle", 32'(req_done), 0);
                chk("rdata_idle", req_rdata, 0);
                cool = 0;
            end else begin
                k++;
                chk("we_hold", 32'(lcd_we), 0);
                chk("grant_hold", 32'(req_grant), 32'(1 << owner));
                eto = !s2 && !b1 && (k - 1 == START_TO);
                eok = s2 && !b1;
                chk("done", 32'(req_done), (eto || eok) ? 32'(1 << owner) : 0);
                chk("rdata", req_rdata, (eok && cur.is_read) ? last_dr : 32'h0);
                s2 |= b1;
                b1 = lcd_busy;
                if (lcd_busy) last_dr = lcd_data_reg;
                if (eto || eok) begin
                    wins.push_back(owner); lats.push_back(k); rds.push_back(req_rdata);
                    if (eok) m_rr = owner; else m_err = 1;
                    owner = -1; cool = 1;
                end
            end
            if (owner >= 0 || ewe)
                chk("bus_fields", {11'h0, lcd_rs_o, lcd_data, lcd_id_fm, lcd_rd_color, 2'b0},
                    {11'h0, cur.rs, cur.data, cur.id_fm, cur.rd_color, 2'b0});
            pv = req_valid; pinit = init_active;
            for (int i = 0; i < 2; i++)
                pr[i] = '{rs: req_rs[i], data: req_data[i], is_read: req_is_read[i],
                          id_fm: req_id_fm[i], rd_color: req_rd_color[i]};
        end
    end

    task automatic set_req(input int r, input logic rs, input logic [15:0] d, input logic rd,
                           input logic idf, input logic col);
        req_rs[r] = rs; req_data[r] = d; req_is_read[r] = rd; req_id_fm[r] = idf; req_rd_color[r] = col;
        req_valid[r] = 1'b1;
    endtask

    task automatic await_n(input int n);
        int t = 0;
        while (wins.size() < n && t < 300) begin
            @(negedge pclk); #1;
            t++;
        end
        chk("await", 32'(wins.size()), 32'(n));
    endtask

    task automatic drop();
        @(posedge pclk); #2;
        req_valid = '0;
    endtask

    int b, t;
    initial begin
        rst = 1'b1;
        @(negedge pclk); #1;
        chk("reset_grant", 32'(req_grant), 0);
        chk("reset_err", 32'(req_err), 0);
        @(posedge pclk); @(posedge pclk); #2;
        rst = 1'b0;

        // Init write under priority.
        @(posedge pclk); #2;
        init_active = 1'b1; eng_res = '0; eng_dly = 1; eng_span = 4;
        b = wins.size();
        set_req(0, 1'b0, 16'h0011, 1'b0, 1'b0, 1'b0);
        await_n(b + 1); drop();
        chk("init_winner", 32'(wins[b]), 0);
        chk("init_latency", 32'(lats[b]), 6);
        chk("init_rdata", rds[b], 0);

        // ID read from the CPU bridge.
        init_active = 1'b0; eng_res = 32'h00009341; eng_dly = 2;
        b = wins.size();
        set_req(1, 1'b0, 16'h00D3, 1'b1, 1'b0, 1'b0);
        await_n(b + 1); drop();
        chk("id_winner", 32'(wins[b]), 1);
        chk("id_latency", 32'(lats[b]), 7);
        chk("id_rdata", rds[b], 32'h00009341);

        // Two-beat colour read.
        eng_res = 32'h12345678; eng_dly = 1;
        b = wins.size();
        set_req(1, 1'b1, 16'h002E, 1'b1, 1'b1, 1'b1);
        await_n(b + 1); drop();
        chk("color_rdata", rds[b], 32'h12345678);
        chk("color_latency", 32'(lats[b]), 6);

        // Round-robin contention, last winner was req 1.
        eng_res = '0;
        b = wins.size();
        set_req(0, 1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
        set_req(1, 1'b1, 16'h5A5A, 1'b0, 1'b1, 1'b0);
        await_n(b + 3); drop();
        chk("rr_0", 32'(wins[b]), 0);
        chk("rr_1", 32'(wins[b + 1]), 1);
        chk("rr_2", 32'(wins[b + 2]), 0);

        // Priority contention.
        init_active = 1'b1;
        b = wins.size();
        set_req(0, 1'b0, 16'h0028, 1'b0, 1'b0, 1'b0);
        set_req(1, 1'b0, 16'h0029, 1'b0, 1'b0, 1'b0);
        await_n(b + 2); drop();
        chk("prio_0", 32'(wins[b]), 0);
        chk("prio_1", 32'(wins[b + 1]), 0);

        // Start timeout: engine never goes busy.
        eng_dead = 1;
        b = wins.size();
        set_req(0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0);
        await_n(b + 1); drop();
        chk("to_winner", 32'(wins[b]), 0);
        chk("to_latency", 32'(lats[b]), START_TO + 1);
        chk("to_rdata", rds[b], 0);
        chk("err_sticky", 32'(req_err), 1);
        eng_dead = 0;

        // Asynchronous reset while waiting for the engine to finish.
        init_active = 1'b0; eng_span = 12;
        set_req(1, 1'b1, 16'h0029, 1'b0, 1'b0, 1'b0);
        t = 0;
        while (!lcd_we && t < 50) begin
            @(negedge pclk);
            t++;
        end
        chk("rst_we_seen", 32'(lcd_we), 1);
        repeat (4) @(posedge pclk);
        #3;
        chk("pre_rst_grant", 32'(req_grant), 32'h2);
        chk("pre_rst_data", 32'(lcd_data), 32'h0029);
        chk("pre_rst_err", 32'(req_err), 1);
        rst = 1'b1; req_valid = '0;
        #1;
        chk("async_grant", 32'(req_grant), 0);
        chk("async_we", 32'(lcd_we), 0);
        chk("async_done", 32'(req_done), 0);
        chk("async_err", 32'(req_err), 0);
        @(posedge pclk); @(posedge pclk); #2;
        rst = 1'b0; eng_span = 4;

        // Normal service after reset.
        @(posedge pclk); #2;
        b = wins.size();
        set_req(0, 1'b0, 16'h0036, 1'b0, 1'b0, 1'b0);
        await_n(b + 1); drop();
        chk("post_winner", 32'(wins[b]), 0);
        chk("post_latency", 32'(lats[b]), 6);
        chk("post_err", 32'(req_err), 0);

        repeat (3) @(posedge pclk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
